// File: rtl/cpuc_reg_dump.sv
`default_nettype none
// ============================================================================
// Module      : cpuc_reg_dump
// Description : Debug/trace read-side consumer of the CPUC register output
//               bus. On a dump request the whole bus (all GP registers plus
//               the PC, PC in the highest word) is snapshotted and streamed
//               out one word per beat over a valid/ready interface, followed
//               by one XOR-checksum beat.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk         in   1                     clock, rising edge
//   Rst_n       in   1                     asynchronous active-low reset
//   DumpReq     in   1                     dump request, level-sampled
//   RegOutputs  in   NUM_WORDS*DATA_WIDTH  register bus, word k at
//                                          [k*DATA_WIDTH +: DATA_WIDTH]
//   OutReady    in   1                     sink ready
//   OutValid    out  1                     beat valid
//   OutData     out  DATA_WIDTH            register word / checksum
//   OutIdx      out  IDX_W                 word index, NUM_WORDS = checksum
//   OutLast     out  1                     high on the checksum beat
//   Busy        out  1                     dump in progress
//   DumpDone    out  1                     pulse after checksum handshake
//   ReqDropCnt  out  8                     saturating dropped-request count
// ============================================================================
module cpuc_reg_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 9,
  parameter int IDX_W      = $clog2(NUM_WORDS + 1)
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic                            DumpReq,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] RegOutputs,
  input  logic                            OutReady,
  output logic                            OutValid,
  output logic [DATA_WIDTH-1:0]           OutData,
  output logic [IDX_W-1:0]                OutIdx,
  output logic                            OutLast,
  output logic                            Busy,
  output logic                            DumpDone,
  output logic [7:0]                      ReqDropCnt
);

  // Index of the final register word and the index reported for the
  // checksum beat. OutIdx tops out at c_CSUM_IDX and never wraps.
  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] c_CSUM_IDX = IDX_W'(NUM_WORDS);
  localparam logic [7:0]       c_DROP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_CSUM = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // Snapshot of the register bus taken in the request cycle; the live bus
  // is never looked at again until the next dump starts.
  logic [DATA_WIDTH-1:0] r_snap [NUM_WORDS];
  logic [DATA_WIDTH-1:0] r_csum;
  logic [IDX_W-1:0]      r_idx;
  logic [7:0]            r_drop_cnt;
  logic                  r_dump_done;

  logic                  w_start;
  logic                  w_word_xfer;
  logic                  w_csum_xfer;
  logic [DATA_WIDTH-1:0] w_word;

  // --------------------------------------------------------------------------
  // Current word select. A compare-based mux keeps the index width
  // independent of the array bound and yields zero for out-of-range indices.
  // --------------------------------------------------------------------------
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_word = r_snap[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and stream outputs. Outputs depend only on registered
  // state, so they stay stable across a stall and drop to zero the instant
  // reset is asserted.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_word_xfer = 1'b0;
    w_csum_xfer = 1'b0;
    OutValid    = 1'b0;
    OutData     = '0;
    OutIdx      = '0;
    OutLast     = 1'b0;
    Busy        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (DumpReq) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end

      ST_SEND: begin
        OutValid    = 1'b1;
        Busy        = 1'b1;
        OutData     = w_word;
        OutIdx      = r_idx;
        w_word_xfer = OutReady;
        if (OutReady && (r_idx == c_LAST_IDX)) begin
          w_state_nxt = ST_CSUM;
        end
      end

      ST_CSUM: begin
        OutValid    = 1'b1;
        Busy        = 1'b1;
        OutData     = r_csum;
        OutIdx      = c_CSUM_IDX;
        OutLast     = 1'b1;
        w_csum_xfer = OutReady;
        if (OutReady) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Snapshot capture
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_snap[k] <= '0;
      end
    end else if (w_start) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        r_snap[k] <= RegOutputs[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Beat index and running checksum. The index stays parked on the last
  // word while the checksum beat is presented rather than advancing past it.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_idx  <= '0;
      r_csum <= '0;
    end else if (w_start) begin
      r_idx  <= '0;
      r_csum <= '0;
    end else if (w_word_xfer) begin
      r_csum <= r_csum ^ w_word;
      if (r_idx != c_LAST_IDX) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Completion pulse: high for exactly the cycle after the checksum beat
  // transfers. An aborted dump (reset) never produces it.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_dump_done <= 1'b0;
    end else begin
      r_dump_done <= w_csum_xfer;
    end
  end

  // --------------------------------------------------------------------------
  // Dropped-request counter: every cycle DumpReq is seen while a dump is
  // active counts once; saturates and only reset clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_drop_cnt <= '0;
    end else if (DumpReq && Busy && (r_drop_cnt != c_DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign DumpDone   = r_dump_done;
  assign ReqDropCnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpuc_reg_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpuc_reg_dump
// Description : Self-checking bench for cpuc_reg_dump. A queue-based model
//               of the dump stream is checked against the DUT every falling
//               edge; directed sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpuc_reg_dump;

  localparam int DW = 32;
  localparam int NW = 9;
  localparam int IW = $clog2(NW + 1);

  logic           clk        = 1'b0;
  logic           rst_n      = 1'b0;
  logic           dump_req   = 1'b0;
  logic           out_ready  = 1'b0;
  logic [NW*DW-1:0] reg_outputs = '0;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [IW-1:0]  out_idx;
  logic           out_last;
  logic           busy;
  logic           dump_done;
  logic [7:0]     drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpuc_reg_dump #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .IDX_W(IW)) u_dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .DumpReq    (dump_req),
    .RegOutputs (reg_outputs),
    .OutReady   (out_ready),
    .OutValid   (out_valid),
    .OutData    (out_data),
    .OutIdx     (out_idx),
    .OutLast    (out_last),
    .Busy       (busy),
    .DumpDone   (dump_done),
    .ReqDropCnt (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: a dump is just the list of beats it will emit. Request in idle
  // builds the list from the bus at that moment; each handshake pops one.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] idx;
    logic          last;
  } beat_t;

  beat_t m_q[$];
  bit    m_busy = 1'b0;
  bit    m_done = 1'b0;
  int    m_drop = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_busy = 1'b0;
      m_done = 1'b0;
      m_drop = 0;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",  32'(busy),      32'd0);
      chk("rst_done",  32'(dump_done), 32'd0);
      chk("rst_drop",  32'(drop_cnt),  32'd0);
      chk("rst_data",  out_data,       32'd0);
      chk("rst_idx",   32'(out_idx),   32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
    end else begin
      chk("mdl_valid", 32'(out_valid), 32'(m_busy));
      chk("mdl_busy",  32'(busy),      32'(m_busy));
      chk("mdl_done",  32'(dump_done), 32'(m_done));
      chk("mdl_drop",  32'(drop_cnt),  32'(m_drop));
      if (m_busy) begin
        chk("mdl_data", out_data,       m_q[0].data);
        chk("mdl_idx",  32'(out_idx),   32'(m_q[0].idx));
        chk("mdl_last", 32'(out_last),  32'(m_q[0].last));
      end
      // predict the state after the coming rising edge
      m_done = 1'b0;
      if (!m_busy) begin
        if (dump_req) begin
          logic [DW-1:0] x;
          x = '0;
          for (int k = 0; k < NW; k++) begin
            m_q.push_back('{data: reg_outputs[k*DW +: DW], idx: IW'(k), last: 1'b0});
            x ^= reg_outputs[k*DW +: DW];
          end
          m_q.push_back('{data: x, idx: IW'(NW), last: 1'b1});
          m_busy = 1'b1;
        end
      end else begin
        if (dump_req && m_drop < 255) m_drop++;
        if (out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs_seq();
    for (int k = 0; k < NW; k++) reg_outputs[k*DW +: DW] = 32'h1000 + 32'(k);
  endtask

  // Runs the sink until DumpDone is seen, counting handshakes and pulses.
  task automatic run_until_done(input bit rand_ready, output int beats,
                                output int dones, output logic [DW-1:0] last_data);
    int  budget;
    bit  seen;
    beats     = 0;
    dones     = 0;
    last_data = '0;
    budget    = 400;
    seen      = 1'b0;
    while (!seen && budget > 0) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        beats++;
        if (out_last) last_data = out_data;
      end
      tick();
      budget--;
      if (dump_done) begin
        dones++;
        seen = 1'b1;
      end
    end
    if (!seen) chk("timeout_done", 32'd0, 32'd1);
    out_ready = 1'b0;
  endtask

  int            beats, dones;
  logic [DW-1:0] last_data;

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_drop",  32'(drop_cnt),  32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // ---------------- 1: basic zero-bubble dump ----------------
    set_regs_seq();
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t1_valid", 32'(out_valid), 32'd1);
      chk("t1_idx",   32'(out_idx),   32'(i));
      chk("t1_data",  out_data,       (i < 9) ? 32'h1000 + 32'(i) : 32'h0000_1008);
      chk("t1_last",  32'(out_last),  32'(i == 9));
      tick();
    end
    chk("t1_done",   32'(dump_done), 32'd1);
    chk("t1_vlow",   32'(out_valid), 32'd0);
    tick();
    chk("t1_done_off", 32'(dump_done), 32'd0);
    out_ready = 1'b0;

    // ---------------- 2: random back-pressure ----------------
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    run_until_done(1'b1, beats, dones, last_data);
    chk("t2_beats", 32'(beats), 32'd10);
    chk("t2_dones", 32'(dones), 32'd1);
    chk("t2_csum",  last_data,  32'h0000_1008);

    // ---------------- 3: snapshot isolation ----------------
    dump_req = 1'b1;
    tick();
    dump_req    = 1'b0;
    reg_outputs = '1;
    run_until_done(1'b0, beats, dones, last_data);
    chk("t3_beats", 32'(beats), 32'd10);
    chk("t3_csum",  last_data,  32'h0000_1008);
    set_regs_seq();

    // ---------------- 4: dropped requests, saturation ----------------
    out_ready = 1'b0;
    dump_req  = 1'b1;
    tick();
    for (int p = 0; p < 3; p++) begin
      dump_req = 1'b0;
      tick();
      dump_req = 1'b1;
      tick();
    end
    dump_req = 1'b0;
    chk("t4_drop3", 32'(drop_cnt), 32'd3);
    run_until_done(1'b0, beats, dones, last_data);
    chk("t4_beats", 32'(beats), 32'd10);
    chk("t4_dones", 32'(dones), 32'd1);
    tick();
    chk("t4_idle", 32'(busy), 32'd0);
    chk("t4_single_done", 32'(dump_done), 32'd0);
    dump_req = 1'b1;
    repeat (300) tick();
    chk("t4_sat", 32'(drop_cnt), 32'd255);
    dump_req = 1'b0;
    run_until_done(1'b0, beats, dones, last_data);
    chk("t4_sat_hold", 32'(drop_cnt), 32'd255);

    // ---------------- 5: reset mid-dump ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_drop_clr", 32'(drop_cnt), 32'd0);
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
    repeat (4) tick();
    chk("t5_idx4", 32'(out_idx), 32'd4);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_now", 32'(out_valid), 32'd0);
    chk("t5_busy_now",  32'(busy),      32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_no_done", 32'(dump_done), 32'd0);
      tick();
    end
    for (int k = 0; k < NW; k++) reg_outputs[k*DW +: DW] = 32'h1111_1111 * 32'(k);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("t5_restart_idx",  32'(out_idx), 32'd0);
    chk("t5_restart_data", out_data,     32'd0);
    run_until_done(1'b0, beats, dones, last_data);
    chk("t5_beats", 32'(beats), 32'd10);
    chk("t5_csum",  last_data,  32'h8888_8888);

    // ---------------- 6: back-to-back dumps ----------------
    set_regs_seq();
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t6_valid", 32'(out_valid), 32'd1);
      chk("t6_idx",   32'(out_idx),   32'(i));
      tick();
    end
    chk("t6_gap_valid", 32'(out_valid), 32'd0);
    chk("t6_gap_done",  32'(dump_done), 32'd1);
    tick();
    chk("t6_restart_valid", 32'(out_valid), 32'd1);
    chk("t6_restart_idx",   32'(out_idx),   32'd0);
    dump_req = 1'b0;
    run_until_done(1'b0, beats, dones, last_data);
    chk("t6_beats", 32'(beats), 32'd10);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
